// File: rtl/axi4l_dtm.sv
// AXI4-Lite to DMI debug transport: an AXI4-Lite slave that forwards single
// register accesses to a debug module over the DMI request/response link.

package dm;
    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

interface axi4l_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

module axi4l_dtm #(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned AddrLsb       = 2
) (
    input  logic          clk,
    input  logic          rst,
    axi4l_if.slave        axis,
    output logic          dmi_rst_n,
    output logic          dmi_req_valid,
    input  logic          dmi_req_ready,
    output dm::dmi_req_t  dmi_req,
    input  logic          dmi_resp_valid,
    output logic          dmi_resp_ready,
    input  dm::dmi_resp_t dmi_resp
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_BRESP, S_RRESP} state_t;

    state_t       r_state, w_next;
    logic         r_aw_full, r_w_full, r_ar_full;
    logic [6:0]   r_awaddr, r_araddr;
    logic [31:0]  r_wdata;
    logic [3:0]   r_wstrb;
    logic         r_rr_wr, r_is_wr, r_err;
    logic [31:0]  r_rdata, r_cnt;
    dm::dmi_req_t r_req;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
    logic w_wr_rdy, w_rd_rdy, w_pick_wr, w_pick_rd;
    logic w_timeout, w_req_fire, w_resp_fire;
    logic w_unused;

    // Address bits outside the 7-bit DMI window are deliberately dropped.
    assign w_unused = ^{axis.awaddr, axis.araddr};

    assign w_aw_hs     = axis.awvalid && axis.awready;
    assign w_w_hs      = axis.wvalid && axis.wready;
    assign w_ar_hs     = axis.arvalid && axis.arready;
    assign w_b_hs      = (r_state == S_BRESP) && axis.bready;
    assign w_r_hs      = (r_state == S_RRESP) && axis.rready;
    assign w_wr_rdy    = r_aw_full && r_w_full;
    assign w_rd_rdy    = r_ar_full;
    // Round robin only moves when both types compete in the same cycle.
    assign w_pick_wr   = (r_state == S_IDLE) && w_wr_rdy && (!w_rd_rdy || r_rr_wr);
    assign w_pick_rd   = (r_state == S_IDLE) && w_rd_rdy && !w_pick_wr;
    assign w_timeout   = (TimeoutCycles != 0) && (r_state == S_REQ || r_state == S_RESP)
                         && (r_cnt == TimeoutCycles);
    assign w_req_fire  = (r_state == S_REQ) && !w_timeout && dmi_req_ready;
    assign w_resp_fire = (r_state == S_RESP) && !w_timeout && dmi_resp_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_wr)      w_next = (r_wstrb == 4'hF) ? S_REQ : S_BRESP;
                else if (w_pick_rd) w_next = S_REQ;
            end
            S_REQ: begin
                if (w_timeout)       w_next = r_is_wr ? S_BRESP : S_RRESP;
                else if (w_req_fire) w_next = S_RESP;
            end
            S_RESP: begin
                if (w_timeout || w_resp_fire) w_next = r_is_wr ? S_BRESP : S_RRESP;
            end
            S_BRESP: if (w_b_hs) w_next = S_IDLE;
            S_RRESP: if (w_r_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        axis.awready   = !rst && !r_aw_full;
        axis.wready    = !rst && !r_w_full;
        axis.arready   = !rst && !r_ar_full;
        axis.bvalid    = !rst && (r_state == S_BRESP);
        axis.rvalid    = !rst && (r_state == S_RRESP);
        axis.bresp     = r_err ? 2'b10 : 2'b00;
        axis.rresp     = r_err ? 2'b10 : 2'b00;
        axis.rdata     = r_rdata;
        dmi_req_valid  = !rst && (r_state == S_REQ) && !w_timeout;
        dmi_resp_ready = !rst && (r_state == S_RESP) && !w_timeout;
        dmi_rst_n      = !rst && !w_timeout;
        dmi_req        = r_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_ar_full <= 1'b0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rr_wr   <= 1'b1;
            r_is_wr   <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_req     <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= axis.awaddr[AddrLsb+6:AddrLsb];
            end else if (w_b_hs) begin
                r_aw_full <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= axis.wdata;
                r_wstrb  <= axis.wstrb;
            end else if (w_b_hs) begin
                r_w_full <= 1'b0;
            end
            if (w_ar_hs) begin
                r_ar_full <= 1'b1;
                r_araddr  <= axis.araddr[AddrLsb+6:AddrLsb];
            end else if (w_r_hs) begin
                r_ar_full <= 1'b0;
            end

            if (r_state == S_IDLE && w_wr_rdy && w_rd_rdy) r_rr_wr <= !r_rr_wr;

            if (w_pick_wr) begin
                r_is_wr <= 1'b1;
                r_req   <= '{addr: r_awaddr, data: r_wdata, op: 2'd2};
                if (r_wstrb != 4'hF) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end else begin
                    r_cnt <= '0;
                end
            end else if (w_pick_rd) begin
                r_is_wr <= 1'b0;
                r_req   <= '{addr: r_araddr, data: 32'h0, op: 2'd1};
                r_cnt   <= '0;
            end

            if (r_state == S_REQ || r_state == S_RESP) r_cnt <= r_cnt + 32'd1;

            if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end else if (w_resp_fire) begin
                r_err   <= (dmi_resp.resp != 2'd0);
                r_rdata <= (dmi_resp.resp == 2'd0) ? dmi_resp.data : 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_axi4l_dtm.sv
// Scoreboard bench for axi4l_dtm: expected DMI requests and B/R responses are
// queued as stimulus is driven and checked as the DUT produces them.

module tb_axi4l_dtm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4l_if bus();
    logic          dmi_rst_n, dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
    dm::dmi_req_t  dmi_req;
    dm::dmi_resp_t dmi_resp;

    int n_checks = 0;
    int n_errors = 0;

    dm::dmi_req_t exp_req_q[$];
    logic [1:0]   exp_b_q[$];
    logic [33:0]  exp_r_q[$];   // {rdata, rresp}

    axi4l_dtm #(.TimeoutCycles(8), .AddrLsb(2)) dut (
        .clk(clk), .rst(rst), .axis(bus),
        .dmi_rst_n(dmi_rst_n), .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req(dmi_req), .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp(dmi_resp)
    );

    function automatic dm::dmi_req_t mk_wr(input logic [31:0] a, input logic [31:0] d);
        return '{addr: a[8:2], data: d, op: 2'd2};
    endfunction

    function automatic dm::dmi_req_t mk_rd(input logic [31:0] a);
        return '{addr: a[8:2], data: 32'h0, op: 2'd1};
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int i = 0; i < 40 && !(bus.awready && bus.wready); i++) @(negedge clk);
        n_checks++;
        if (!(bus.awready && bus.wready)) begin
            n_errors++;
            $display("FAIL aw_w_accept: awready=%b wready=%b required 1 1", bus.awready, bus.wready);
        end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a);
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int i = 0; i < 40 && !bus.arready; i++) @(negedge clk);
        n_checks++;
        if (!bus.arready) begin
            n_errors++;
            $display("FAIL ar_accept: arready=%b required 1", bus.arready);
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic dm_serve(input string name, input logic [31:0] rdat, input logic [1:0] rcode);
        dm::dmi_req_t exp;
        for (int i = 0; i < 40 && !dmi_req_valid; i++) @(negedge clk);
        n_checks++;
        if (!dmi_req_valid) begin
            n_errors++;
            $display("FAIL %s_req_valid: got %b required 1", name, dmi_req_valid);
            return;
        end
        exp = (exp_req_q.size() != 0) ? exp_req_q.pop_front() : 'x;
        n_checks++;
        if (dmi_req !== exp) begin
            n_errors++;
            $display("FAIL %s_req: got %h required %h", name, dmi_req, exp);
        end
        dmi_req_ready = 1'b1;
        @(negedge clk);
        dmi_req_ready = 1'b0;
        for (int i = 0; i < 40 && !dmi_resp_ready; i++) @(negedge clk);
        n_checks++;
        if (!dmi_resp_ready) begin
            n_errors++;
            $display("FAIL %s_resp_ready: got %b required 1", name, dmi_resp_ready);
            return;
        end
        dmi_resp = '{data: rdat, resp: rcode};
        dmi_resp_valid = 1'b1;
        @(negedge clk);
        dmi_resp_valid = 1'b0;
    endtask

    task automatic wait_b(input string name, input int hold);
        logic [1:0] exp;
        for (int i = 0; i < 40 && !bus.bvalid; i++) @(negedge clk);
        n_checks++;
        if (!bus.bvalid) begin
            n_errors++;
            $display("FAIL %s_bvalid: got %b required 1", name, bus.bvalid);
            return;
        end
        exp = (exp_b_q.size() != 0) ? exp_b_q.pop_front() : 2'bxx;
        n_checks++;
        if (bus.bresp !== exp) begin
            n_errors++;
            $display("FAIL %s_bresp: got %b required %b", name, bus.bresp, exp);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== exp) begin
                n_errors++;
                $display("FAIL %s_b_hold: bvalid=%b bresp=%b required 1 %b", name, bus.bvalid, bus.bresp, exp);
            end
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        n_checks++;
        if (bus.bvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_b_drop: bvalid=%b required 0", name, bus.bvalid);
        end
    endtask

    task automatic wait_r(input string name, input int hold);
        logic [33:0] exp;
        for (int i = 0; i < 40 && !bus.rvalid; i++) @(negedge clk);
        n_checks++;
        if (!bus.rvalid) begin
            n_errors++;
            $display("FAIL %s_rvalid: got %b required 1", name, bus.rvalid);
            return;
        end
        exp = (exp_r_q.size() != 0) ? exp_r_q.pop_front() : 'x;
        n_checks++;
        if ({bus.rdata, bus.rresp} !== exp) begin
            n_errors++;
            $display("FAIL %s_r: got rdata=%h rresp=%b required rdata=%h rresp=%b",
                     name, bus.rdata, bus.rresp, exp[33:2], exp[1:0]);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rvalid !== 1'b1 || {bus.rdata, bus.rresp} !== exp) begin
                n_errors++;
                $display("FAIL %s_r_hold: rvalid=%b rdata=%h rresp=%b required 1 %h %b",
                         name, bus.rvalid, bus.rdata, bus.rresp, exp[33:2], exp[1:0]);
            end
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        n_checks++;
        if (bus.rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_r_drop: rvalid=%b required 0", name, bus.rvalid);
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        got = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
               dmi_req_valid, dmi_resp_ready, dmi_rst_n};
        n_checks++;
        if (got !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b required 00000000", got);
        end
        rst = 1'b0;
        #1;
        got = {4'b0, bus.awready, bus.wready, bus.arready, dmi_rst_n};
        n_checks++;
        if (got !== 8'h0F) begin
            n_errors++;
            $display("FAIL reset_release: got %b required 00001111", got);
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        exp_req_q.push_back(mk_wr(32'h40, 32'h0000_0001));
        exp_b_q.push_back(2'b00);
        axi_write(32'h40, 32'h0000_0001, 4'hF);
        dm_serve("write", 32'h0, 2'd0);
        wait_b("write", 0);
    endtask

    task automatic test_read();
        exp_req_q.push_back(mk_rd(32'h44));
        exp_r_q.push_back({32'h1234_5678, 2'b00});
        axi_read(32'h44);
        dm_serve("read", 32'h1234_5678, 2'd0);
        wait_r("read", 0);
    endtask

    task automatic collide(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
        bus.awaddr = wa; bus.wdata = wd; bus.wstrb = 4'hF; bus.araddr = ra;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    endtask

    task automatic test_arbitration();
        apply_reset();
        exp_req_q.push_back(mk_wr(32'h08, 32'hAAAA_5555));
        exp_b_q.push_back(2'b00);
        exp_req_q.push_back(mk_rd(32'h0C));
        exp_r_q.push_back({32'hCAFE_F00D, 2'b00});
        collide(32'h08, 32'hAAAA_5555, 32'h0C);
        dm_serve("arb1_wr", 32'h0, 2'd0);
        wait_b("arb1_wr", 0);
        dm_serve("arb1_rd", 32'hCAFE_F00D, 2'd0);
        wait_r("arb1_rd", 0);

        exp_req_q.push_back(mk_rd(32'h1C));
        exp_r_q.push_back({32'h0BAD_CAFE, 2'b00});
        exp_req_q.push_back(mk_wr(32'h18, 32'h5555_AAAA));
        exp_b_q.push_back(2'b00);
        collide(32'h18, 32'h5555_AAAA, 32'h1C);
        dm_serve("arb2_rd", 32'h0BAD_CAFE, 2'd0);
        wait_r("arb2_rd", 0);
        dm_serve("arb2_wr", 32'h0, 2'd0);
        wait_b("arb2_wr", 0);
    endtask

    task automatic test_bad_strb();
        logic seen_req = 1'b0;
        exp_b_q.push_back(2'b10);
        axi_write(32'h30, 32'h1111_2222, 4'h3);
        for (int i = 0; i < 40 && !bus.bvalid; i++) begin
            seen_req |= dmi_req_valid;
            @(negedge clk);
        end
        seen_req |= dmi_req_valid;
        n_checks++;
        if (seen_req !== 1'b0) begin
            n_errors++;
            $display("FAIL strb_no_dmi: dmi_req_valid seen=%b required 0", seen_req);
        end
        wait_b("strb", 0);
    endtask

    task automatic test_timeout();
        int valid_cycles = 0;
        int rstn_low = 0;
        logic compared = 1'b0;
        dm::dmi_req_t exp;
        exp_req_q.push_back(mk_rd(32'h10));
        exp_r_q.push_back({32'h0, 2'b10});
        axi_read(32'h10);
        for (int i = 0; i < 60 && !bus.rvalid; i++) begin
            @(negedge clk);
            if (dmi_req_valid) valid_cycles++;
            if (!dmi_rst_n) rstn_low++;
            if (dmi_req_valid && !compared) begin
                compared = 1'b1;
                exp = exp_req_q.pop_front();
                n_checks++;
                if (dmi_req !== exp) begin
                    n_errors++;
                    $display("FAIL timeout_req: got %h required %h", dmi_req, exp);
                end
            end
        end
        n_checks++;
        if (valid_cycles != 8) begin
            n_errors++;
            $display("FAIL timeout_req_cycles: got %0d required 8", valid_cycles);
        end
        n_checks++;
        if (rstn_low != 1) begin
            n_errors++;
            $display("FAIL timeout_rst_pulse: got %0d cycles required 1", rstn_low);
        end
        wait_r("timeout", 0);

        dmi_resp = '{data: 32'hFFFF_0000, resp: 2'd0};
        dmi_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({dmi_resp_ready, bus.rvalid, bus.bvalid, dmi_req_valid, bus.arready} !== 5'b00001) begin
                n_errors++;
                $display("FAIL stray_resp: resp_ready,rvalid,bvalid,req_valid,arready=%b required 00001",
                         {dmi_resp_ready, bus.rvalid, bus.bvalid, dmi_req_valid, bus.arready});
            end
        end
        dmi_resp_valid = 1'b0;

        exp_req_q.push_back(mk_rd(32'h14));
        exp_r_q.push_back({32'h0000_55AA, 2'b00});
        axi_read(32'h14);
        dm_serve("post_timeout", 32'h0000_55AA, 2'd0);
        wait_r("post_timeout", 0);
    endtask

    task automatic test_busy_backpressure();
        exp_req_q.push_back(mk_rd(32'h20));
        exp_r_q.push_back({32'h0, 2'b10});
        axi_read(32'h20);
        dm_serve("busy", 32'hDEAD_BEEF, 2'd3);
        wait_r("busy", 5);

        exp_req_q.push_back(mk_wr(32'h24, 32'h0000_0077));
        exp_b_q.push_back(2'b10);
        axi_write(32'h24, 32'h0000_0077, 4'hF);
        dm_serve("failed_wr", 32'h0, 2'd2);
        wait_b("failed_wr", 5);

        exp_req_q.push_back(mk_rd(32'h28));
        exp_r_q.push_back({32'h1357_9BDF, 2'b00});
        axi_read(32'h28);
        dm_serve("bp_rd", 32'h1357_9BDF, 2'd0);
        wait_r("bp_rd", 5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            d = $urandom;
            if (i % 2 == 0) begin
                exp_req_q.push_back(mk_wr(a, d));
                exp_b_q.push_back(2'b00);
                axi_write(a, d, 4'hF);
                dm_serve("b2b_wr", 32'h0, 2'd0);
                wait_b("b2b_wr", 0);
            end else begin
                exp_req_q.push_back(mk_rd(a));
                exp_r_q.push_back({d, 2'b00});
                axi_read(a);
                dm_serve("b2b_rd", d, 2'd0);
                wait_r("b2b_rd", 0);
            end
        end
    endtask

    task automatic test_reset_mid();
        dm::dmi_req_t exp;
        exp = mk_wr(32'h3C, 32'h9999_0000);
        axi_write(32'h3C, 32'h9999_0000, 4'hF);
        for (int i = 0; i < 40 && !dmi_req_valid; i++) @(negedge clk);
        n_checks++;
        if (dmi_req !== exp || dmi_req_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_req: valid=%b req=%h required 1 %h", dmi_req_valid, dmi_req, exp);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dmi_rst_n, dmi_req_valid, bus.awready} !== 3'b000) begin
            n_errors++;
            $display("FAIL midrst_in_reset: rst_n,req_valid,awready=%b required 000",
                     {dmi_rst_n, dmi_req_valid, bus.awready});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.bvalid, bus.rvalid, dmi_req_valid, bus.awready, bus.wready, dmi_rst_n} !== 6'b000111) begin
                n_errors++;
                $display("FAIL midrst_abandon: bvalid,rvalid,req_valid,awready,wready,rst_n=%b required 000111",
                         {bus.bvalid, bus.rvalid, dmi_req_valid, bus.awready, bus.wready, dmi_rst_n});
            end
        end
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp = '0;

        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_bad_strb();
        test_timeout();
        test_busy_backpressure();
        test_back_to_back();
        test_reset_mid();

        n_checks++;
        if (exp_req_q.size() != 0 || exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: req=%0d b=%0d r=%0d left required 0 0 0",
                     exp_req_q.size(), exp_b_q.size(), exp_r_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end
endmodule
